// File: rtl/dram_pkg.sv
// Shared types, operation codes and the access-size helper for the SRAM bridge.
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_LB   = 3'd1;
  localparam logic [2:0] RD_LBU  = 3'd2;
  localparam logic [2:0] RD_LH   = 3'd3;
  localparam logic [2:0] RD_LHU  = 3'd4;
  localparam logic [2:0] RD_LW   = 3'd5;
  localparam logic [2:0] RD_LWU  = 3'd6;
  localparam logic [2:0] RD_LD   = 3'd7;

  localparam logic [2:0] WR_NONE = 3'd0;
  localparam logic [2:0] WR_SB   = 3'd1;
  localparam logic [2:0] WR_SH   = 3'd2;
  localparam logic [2:0] WR_SW   = 3'd3;
  localparam logic [2:0] WR_SD   = 3'd4;

  // Access size in bytes; zero marks "no access" or an illegal store code.
  function automatic logic [3:0] size_of(input logic is_store, input logic [2:0] code);
    logic [3:0] sz;
    sz = 4'd0;
    if (is_store) begin
      case (code)
        WR_SB:   sz = 4'd1;
        WR_SH:   sz = 4'd2;
        WR_SW:   sz = 4'd4;
        WR_SD:   sz = 4'd8;
        default: sz = 4'd0;
      endcase
    end else begin
      case (code)
        RD_LB, RD_LBU: sz = 4'd1;
        RD_LH, RD_LHU: sz = 4'd2;
        RD_LW, RD_LWU: sz = 4'd4;
        RD_LD:         sz = 4'd8;
        default:       sz = 4'd0;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dram_ctrl_param_if.sv
// Core-side load/store port of the SRAM bridge.
interface dram_ctrl_param_if;
  logic [2:0]  dm_rd_ctrl;
  logic [2:0]  dm_wr_ctrl;
  logic [63:0] dm_addr;
  logic [63:0] dm_din;
  logic [63:0] dm_dout;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output dm_rd_ctrl, dm_wr_ctrl, dm_addr, dm_din,
    input  dm_dout, busy, done, err
  );

  modport slave (
    input  dm_rd_ctrl, dm_wr_ctrl, dm_addr, dm_din,
    output dm_dout, busy, done, err
  );
endinterface

// File: rtl/dram_lane_fmt.sv
// Combinational lane steering: store data placement, byte enables and load extension.
module dram_lane_fmt
  import dram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BEAT_W = 3
) (
  input  logic [3:0]          size,
  input  logic [3:0]          off,
  input  logic [BEAT_W-1:0]   beat,
  input  logic [2:0]          code,
  input  logic [63:0]         din,
  input  logic [63:0]         rd_word,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] be,
  output logic [63:0]         ext
);
  localparam int BYTES = DATA_W / 8;

  logic        narrow;
  logic [15:0] mask;
  logic [63:0] r;

  // Narrow accesses live in one bus word at a byte offset; wide ones are sliced per beat.
  always_comb begin
    narrow = size < 4'(BYTES);
    mask   = (16'd1 << size) - 16'd1;
    if (narrow) begin
      wdata = DATA_W'(din) << {off, 3'b000};
      be    = BYTES'(mask << off);
      r     = rd_word >> {off, 3'b000};
    end else begin
      wdata = DATA_W'(din >> (int'(beat) * DATA_W));
      be    = '1;
      r     = rd_word;
    end
    case (code)
      RD_LB:   ext = {{56{r[7]}}, r[7:0]};
      RD_LBU:  ext = {56'd0, r[7:0]};
      RD_LH:   ext = {{48{r[15]}}, r[15:0]};
      RD_LHU:  ext = {48'd0, r[15:0]};
      RD_LW:   ext = {{32{r[31]}}, r[31:0]};
      RD_LWU:  ext = {32'd0, r[31:0]};
      RD_LD:   ext = r;
      default: ext = 64'd0;
    endcase
  end

endmodule

// File: rtl/dram_ctrl_param.sv
// Bridge from the 64-bit MEM-stage port to a narrow asynchronous SRAM, one beat per bus word.
module dram_ctrl_param
  import dram_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 19,
  parameter logic [63:0] BASE     = 64'h8000_0000,
  parameter int          WAIT_CYC = 0
) (
  input  logic                clk,
  input  logic                rst,
  dram_ctrl_param_if.slave    bus,
  output state_t              state,
  inout  wire  [DATA_W-1:0]   data,
  output logic                write_en,
  output logic [DATA_W/8-1:0] be,
  output logic [ADDR_W-1:0]   addr
);
  localparam int BYTES   = DATA_W / 8;
  localparam int LANE_SH = $clog2(BYTES);
  localparam int BEAT_W  = $clog2(8 * 8 / DATA_W + 1);
  localparam logic [64:0] WIN_END = {1'b0, BASE} + (65'd1 << (ADDR_W + LANE_SH));

  state_t              state_n;
  logic                req, req_store, req_err;
  logic [2:0]          req_code;
  logic [3:0]          req_size;
  logic                store_q, err_q;
  logic [2:0]          code_q;
  logic [3:0]          size_q, off_q, wait_q;
  logic [63:0]         din_q, rbuf, rbuf_now, ext;
  logic [ADDR_W-1:0]   word_q;
  logic [BEAT_W-1:0]   beat_q, n_beats;
  logic                beat_end, last_beat, sample;
  logic [DATA_W-1:0]   wdata;
  logic [BYTES-1:0]    be_lane;

  assign n_beats   = (size_q > 4'(BYTES)) ? BEAT_W'(size_q >> LANE_SH) : BEAT_W'(1);
  assign beat_end  = wait_q == 4'(WAIT_CYC);
  assign last_beat = beat_q == n_beats - BEAT_W'(1);
  assign sample    = (state == ACCESS) && !store_q && beat_end;
  assign addr      = word_q + ADDR_W'(beat_q);
  assign data      = write_en ? wdata : 'z;

  // Decode the incoming request; a store beats a simultaneous load.
  always_comb begin
    req       = (bus.dm_wr_ctrl != WR_NONE) || (bus.dm_rd_ctrl != RD_NONE);
    req_store = bus.dm_wr_ctrl != WR_NONE;
    req_code  = req_store ? bus.dm_wr_ctrl : bus.dm_rd_ctrl;
    req_size  = size_of(req_store, req_code);
    req_err   = (req_size == 4'd0)
             || ((bus.dm_addr[3:0] & (req_size - 4'd1)) != 4'd0)
             || (bus.dm_addr < BASE)
             || (({1'b0, bus.dm_addr} + 65'(req_size)) > WIN_END);
  end

  // Merge the beat being sampled into the read buffer so the final beat is visible to extension.
  always_comb begin
    rbuf_now = rbuf;
    if (sample) rbuf_now[int'(beat_q) * DATA_W +: DATA_W] = data;
  end

  dram_lane_fmt #(.DATA_W(DATA_W), .BEAT_W(BEAT_W)) u_lane_fmt (
    .size    (size_q),
    .off     (off_q),
    .beat    (beat_q),
    .code    (code_q),
    .din     (din_q),
    .rd_word (rbuf_now),
    .wdata   (wdata),
    .be      (be_lane),
    .ext     (ext)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and pin/handshake outputs.
  always_comb begin
    state_n  = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.err  = 1'b0;
    write_en = 1'b0;
    be       = '0;
    case (state)
      IDLE: if (req) state_n = req_err ? DONE : ACCESS;
      ACCESS: begin
        bus.busy = 1'b1;
        write_en = store_q;
        be       = be_lane;
        if (beat_end && last_beat) state_n = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latches, beat/wait counters, read buffer and the held load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 3'd0;
      size_q      <= 4'd0;
      off_q       <= 4'd0;
      wait_q      <= 4'd0;
      din_q       <= 64'd0;
      rbuf        <= 64'd0;
      word_q      <= '0;
      beat_q      <= '0;
      bus.dm_dout <= 64'd0;
    end else begin
      case (state)
        IDLE: if (req) begin
          store_q     <= req_store;
          err_q       <= req_err;
          code_q      <= req_code;
          size_q      <= req_size;
          off_q       <= bus.dm_addr[3:0] & 4'(BYTES - 1);
          din_q       <= bus.dm_din;
          word_q      <= ADDR_W'((bus.dm_addr - BASE) >> LANE_SH);
          wait_q      <= 4'd0;
          beat_q      <= '0;
          rbuf        <= 64'd0;
          bus.dm_dout <= 64'd0;
        end
        ACCESS: begin
          rbuf <= rbuf_now;
          if (beat_end) begin
            wait_q <= 4'd0;
            if (!last_beat)    beat_q      <= beat_q + BEAT_W'(1);
            else if (!store_q) bus.dm_dout <= ext;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl_param.sv
// Directed bench for dram_ctrl_param: two instances (no wait states and WAIT_CYC=2) on small SRAM models.
module tb_dram_ctrl_param;
  import dram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_ctrl_param_if bus0();
  dram_ctrl_param_if bus1();

  state_t      state0, state1;
  wire  [15:0] data0, data1;
  logic        we0, we1;
  logic [1:0]  be0, be1;
  logic [18:0] addr0, addr1;
  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];

  dram_ctrl_param #(.DATA_W(16), .ADDR_W(19), .BASE(64'h8000_0000), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state(state0),
    .data(data0), .write_en(we0), .be(be0), .addr(addr0)
  );

  dram_ctrl_param #(.DATA_W(16), .ADDR_W(19), .BASE(64'h8000_0000), .WAIT_CYC(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state(state1),
    .data(data1), .write_en(we1), .be(be1), .addr(addr1)
  );

  assign data0 = (state0 == ACCESS && !we0) ? mem0[addr0[5:0]] : 16'bz;
  assign data1 = (state1 == ACCESS && !we1) ? mem1[addr1[5:0]] : 16'bz;

  int checks = 0;
  int errors = 0;
  int wcnt = 0, rcnt = 0, doneCnt = 0;
  int wBase, rBase, dBase, cyc;
  logic        gotErr;
  logic [63:0] gotDout;
  logic [18:0] wAddr [64];
  logic [15:0] wData [64];
  logic [1:0]  wBe   [64];

  // SRAM write model with per-lane enables.
  always @(posedge clk) begin
    if (we0) begin
      if (be0[0]) mem0[addr0[5:0]][7:0]  <= data0[7:0];
      if (be0[1]) mem0[addr0[5:0]][15:8] <= data0[15:8];
    end
    if (we1) begin
      if (be1[0]) mem1[addr1[5:0]][7:0]  <= data1[7:0];
      if (be1[1]) mem1[addr1[5:0]][15:8] <= data1[15:8];
    end
  end

  // Log every write strobe cycle, read beat cycle and done pulse of instance 0.
  always @(negedge clk) begin
    if (we0) begin
      if (wcnt < 64) begin
        wAddr[wcnt] = addr0;
        wData[wcnt] = data0;
        wBe[wcnt]   = be0;
      end
      wcnt++;
    end else if (state0 == ACCESS) begin
      rcnt++;
    end
    if (bus0.done) doneCnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearControls();
    bus0.dm_rd_ctrl = 3'd0; bus0.dm_wr_ctrl = 3'd0; bus0.dm_addr = 64'd0; bus0.dm_din = 64'd0;
    bus1.dm_rd_ctrl = 3'd0; bus1.dm_wr_ctrl = 3'd0; bus1.dm_addr = 64'd0; bus1.dm_din = 64'd0;
  endtask

  task automatic applyStimulus(input bit sel, input logic [2:0] rd, input logic [2:0] wr,
                               input logic [63:0] a, input logic [63:0] d);
    logic dn;
    @(posedge clk);
    @(negedge clk);
    wBase = wcnt;
    rBase = rcnt;
    if (sel) begin
      bus1.dm_rd_ctrl = rd; bus1.dm_wr_ctrl = wr; bus1.dm_addr = a; bus1.dm_din = d;
    end else begin
      bus0.dm_rd_ctrl = rd; bus0.dm_wr_ctrl = wr; bus0.dm_addr = a; bus0.dm_din = d;
    end
    @(posedge clk);
    #1;
    clearControls();
    cyc = 1;
    dn  = sel ? bus1.done : bus0.done;
    while (!dn && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      dn = sel ? bus1.done : bus0.done;
    end
    gotErr  = sel ? bus1.err : bus0.err;
    gotDout = sel ? bus1.dm_dout : bus0.dm_dout;
    if (!dn) checkOutput("done_timeout", 64'(dn), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    clearControls();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_state", 64'(state0), 64'(IDLE));
    checkOutput("rst_busy",  64'(bus0.busy), 64'd0);
    checkOutput("rst_done",  64'(bus0.done), 64'd0);
    checkOutput("rst_err",   64'(bus0.err), 64'd0);
    checkOutput("rst_we",    64'(we0), 64'd0);
    checkOutput("rst_be",    64'(be0), 64'd0);
    checkOutput("rst_addr",  64'(addr0), 64'd0);
    checkOutput("rst_dout",  bus0.dm_dout, 64'd0);

    $display("[TB] SD then LD, no wait states");
    applyStimulus(1'b0, RD_NONE, WR_SD, 64'h8000_0008, 64'h1122_3344_5566_7788);
    checkOutput("sd_cycles", 64'(cyc), 64'd5);
    checkOutput("sd_err",    64'(gotErr), 64'd0);
    checkOutput("sd_beats",  64'(wcnt - wBase), 64'd4);
    for (int k = 0; k < 4; k++) begin
      logic [63:0] expD;
      expD = 64'h1122_3344_5566_7788 >> (16 * k);
      checkOutput($sformatf("sd_addr%0d", k), 64'(wAddr[wBase + k]), 64'(4 + k));
      checkOutput($sformatf("sd_data%0d", k), 64'(wData[wBase + k]), {48'd0, expD[15:0]});
      checkOutput($sformatf("sd_be%0d", k),   64'(wBe[wBase + k]), 64'd3);
    end

    applyStimulus(1'b0, RD_LD, WR_NONE, 64'h8000_0008, 64'd0);
    checkOutput("ld_cycles", 64'(cyc), 64'd5);
    checkOutput("ld_dout",   gotDout, 64'h1122_3344_5566_7788);
    checkOutput("ld_rbeats", 64'(rcnt - rBase), 64'd4);
    checkOutput("ld_nowr",   64'(wcnt - wBase), 64'd0);

    $display("[TB] byte store and sign/zero-extended byte loads");
    applyStimulus(1'b0, RD_NONE, WR_SB, 64'h8000_0003, 64'h0000_0000_0000_00FF);
    checkOutput("sb_cycles", 64'(cyc), 64'd2);
    checkOutput("sb_beats",  64'(wcnt - wBase), 64'd1);
    checkOutput("sb_addr",   64'(wAddr[wBase]), 64'd1);
    checkOutput("sb_data",   64'(wData[wBase][15:8]), 64'hFF);
    checkOutput("sb_be",     64'(wBe[wBase]), 64'd2);
    applyStimulus(1'b0, RD_LB, WR_NONE, 64'h8000_0003, 64'd0);
    checkOutput("lb_dout",   gotDout, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1'b0, RD_LBU, WR_NONE, 64'h8000_0003, 64'd0);
    checkOutput("lbu_dout",  gotDout, 64'h0000_0000_0000_00FF);

    $display("[TB] out-of-window and misaligned requests");
    applyStimulus(1'b0, RD_LW, WR_NONE, 64'h0000_1000, 64'd0);
    checkOutput("oow_cycles", 64'(cyc), 64'd1);
    checkOutput("oow_err",    64'(gotErr), 64'd1);
    checkOutput("oow_dout",   gotDout, 64'd0);
    checkOutput("oow_we",     64'(wcnt - wBase), 64'd0);
    applyStimulus(1'b0, RD_LH, WR_NONE, 64'h8000_0001, 64'd0);
    checkOutput("mis_cycles", 64'(cyc), 64'd1);
    checkOutput("mis_err",    64'(gotErr), 64'd1);
    checkOutput("mis_dout",   gotDout, 64'd0);
    checkOutput("mis_we",     64'(wcnt - wBase), 64'd0);

    $display("[TB] simultaneous load and store");
    applyStimulus(1'b0, RD_LD, WR_SW, 64'h8000_0010, 64'h0000_0000_DEAD_BEEF);
    checkOutput("both_cycles", 64'(cyc), 64'd3);
    checkOutput("both_err",    64'(gotErr), 64'd0);
    checkOutput("both_beats",  64'(wcnt - wBase), 64'd2);
    checkOutput("both_reads",  64'(rcnt - rBase), 64'd0);
    checkOutput("both_d0",     64'(wData[wBase]), 64'hBEEF);
    checkOutput("both_d1",     64'(wData[wBase + 1]), 64'hDEAD);
    checkOutput("both_a1",     64'(wAddr[wBase + 1]), 64'd9);

    $display("[TB] reset during the second beat of an SD");
    @(posedge clk);
    @(negedge clk);
    wBase = wcnt;
    bus0.dm_wr_ctrl = WR_SD; bus0.dm_addr = 64'h8000_0020; bus0.dm_din = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge clk);
    #1;
    clearControls();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_state", 64'(state0), 64'(IDLE));
    checkOutput("abort_we",    64'(we0), 64'd0);
    checkOutput("abort_busy",  64'(bus0.busy), 64'd0);
    dBase = doneCnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_nodone", 64'(doneCnt - dBase), 64'd0);
    checkOutput("abort_beats",  64'(wcnt - wBase), 64'd1);
    checkOutput("abort_part",   64'(mem0[16]), 64'hDDDD);
    applyStimulus(1'b0, RD_LH, WR_NONE, 64'h8000_0020, 64'd0);
    checkOutput("post_lh_cycles", 64'(cyc), 64'd2);
    checkOutput("post_lh_dout",   gotDout, 64'hFFFF_FFFF_FFFF_DDDD);

    $display("[TB] WAIT_CYC=2 instance");
    applyStimulus(1'b1, RD_NONE, WR_SD, 64'h8000_0008, 64'h1122_3344_5566_7788);
    checkOutput("w2_sd_cycles", 64'(cyc), 64'd13);
    applyStimulus(1'b1, RD_LD, WR_NONE, 64'h8000_0008, 64'd0);
    checkOutput("w2_ld_cycles", 64'(cyc), 64'd13);
    checkOutput("w2_ld_dout",   gotDout, 64'h1122_3344_5566_7788);
    checkOutput("w2_ld_err",    64'(gotErr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
